// File: rtl/tf_stream_gen.sv
// Modular twiddle stream: NCH lockstep channels of t*step or t*t mod N, latency start->first term 2 cycles.
// Valid/ready output; terms, last flag, counter and state all hold while tf_valid=1 and tf_ready=0.
module tf_stream_gen #(
    parameter int P_WIDTH = 64,
    parameter int NCH     = 4,
    parameter int CNT_W   = 13
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic [CNT_W-1:0]       len,
    input  logic [P_WIDTH-1:0]     N_in,
    input  logic [P_WIDTH-1:0]     step_in,
    input  logic [NCH*P_WIDTH-1:0] base_in,
    output logic [NCH*P_WIDTH-1:0] tf_out,
    output logic                   tf_valid,
    input  logic                   tf_ready,
    output logic                   tf_last,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_mode;
    logic [CNT_W-1:0]     r_len;
    logic [CNT_W-1:0]     r_k;
    logic [P_WIDTH-1:0]   r_n;
    logic [P_WIDTH-1:0]   r_step;
    logic [P_WIDTH-1:0]   r_term [NCH];

    logic                 w_xfer;
    logic                 w_last;
    logic [P_WIDTH-1:0]   w_mul_b [NCH];
    logic [2*P_WIDTH-1:0] w_prod  [NCH];
    logic [P_WIDTH-1:0]   w_red   [NCH];

    assign w_xfer = (r_state == S_RUN) && tf_ready;
    // len is nonzero whenever RUN is reached, so len-1 never underflows here
    assign w_last = (r_k == r_len - CNT_W'(1));

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_mul_b[c] = r_mode ? r_term[c] : r_step;
            w_prod[c]  = {{P_WIDTH{1'b0}}, r_term[c]} * {{P_WIDTH{1'b0}}, w_mul_b[c]};
            w_red[c]   = P_WIDTH'(w_prod[c] % {{P_WIDTH{1'b0}}, r_n});
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = (r_len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_xfer && w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_len   <= '0;
            r_k     <= '0;
            r_n     <= '0;
            r_step  <= '0;
            for (int c = 0; c < NCH; c++) r_term[c] <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_len  <= len;
                        r_n    <= N_in;
                        r_step <= step_in;
                        for (int c = 0; c < NCH; c++)
                            r_term[c] <= base_in[c*P_WIDTH +: P_WIDTH];
                    end
                end
                S_LOAD: begin
                    r_k    <= '0;
                    r_step <= r_step % r_n;
                    for (int c = 0; c < NCH; c++) r_term[c] <= r_term[c] % r_n;
                end
                S_RUN: begin
                    if (w_xfer && !w_last) begin
                        r_k <= r_k + CNT_W'(1);
                        for (int c = 0; c < NCH; c++) r_term[c] <= w_red[c];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tf_out = '0;
        for (int c = 0; c < NCH; c++) tf_out[c*P_WIDTH +: P_WIDTH] = r_term[c];
    end

    assign tf_valid = (r_state == S_RUN);
    assign tf_last  = (r_state == S_RUN) && w_last;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_tf_stream_gen.sv
// Directed bench for tf_stream_gen: hand-computed modular sequences, backpressure, reset, and length boundaries.
module tb_tf_stream_gen;
    localparam int P  = 64;
    localparam int NC = 4;
    localparam int CW = 13;
    localparam logic [P-1:0] NBIG = 64'hFFFF_FFFF_FFFF_FFC5;

    logic            clk = 1'b0;
    logic            rst_n, start, mode, tf_ready;
    logic [CW-1:0]   len;
    logic [P-1:0]    N_in, step_in;
    logic [NC*P-1:0] base_in;
    logic [NC*P-1:0] tf_out;
    logic            tf_valid, tf_last, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    tf_stream_gen #(.P_WIDTH(P), .NCH(NC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .len(len),
        .N_in(N_in), .step_in(step_in), .base_in(base_in), .tf_out(tf_out),
        .tf_valid(tf_valid), .tf_ready(tf_ready), .tf_last(tf_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge; returns at cycle 1 (LOAD).
    task automatic kick(input logic m, input int l, input logic [P-1:0] n, input logic [P-1:0] s,
                        input logic [P-1:0] b0, input logic [P-1:0] b1,
                        input logic [P-1:0] b2, input logic [P-1:0] b3);
        logic [31:0] lv;
        lv      = l;
        mode    = m;
        len     = lv[CW-1:0];
        N_in    = n;
        step_in = s;
        base_in = {b3, b2, b1, b0};
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; tf_ready = 1'b1;
        len = '0; N_in = '0; step_in = '0; base_in = '0;
        tick(); tick();
        n_cmp++;
        if (tf_out !== '0 || tf_valid !== 1'b0 || tf_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b last=%b busy=%b done=%b out=%h, want all zero",
                     tf_valid, tf_last, busy, done, tf_out);
        end
        rst_n = 1'b1;
        tick(); tick();
        n_cmp++;
        if (busy !== 1'b0 || tf_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b valid=%b, want 0 0", busy, tf_valid);
        end
    endtask

    task automatic run_check(input string name, input logic [P-1:0] e0 [4], input logic [P-1:0] e1 [4],
                             input logic [P-1:0] e2 [4], input logic [P-1:0] e3 [4], input int n);
        n_cmp++;
        if (tf_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s_load: got valid=%b busy=%b, want 0 1", name, tf_valid, busy);
        end
        for (int i = 0; i < n; i++) begin
            tick();
            n_cmp++;
            if (tf_valid !== 1'b1 || tf_out !== {e3[i], e2[i], e1[i], e0[i]}) begin
                n_err++;
                $display("FAIL %s_term%0d: got valid=%b out=%h, want 1 %h", name, i, tf_valid, tf_out,
                         {e3[i], e2[i], e1[i], e0[i]});
            end
            n_cmp++;
            if (tf_last !== (i == n - 1)) begin
                n_err++;
                $display("FAIL %s_last%0d: got %b, want %b", name, i, tf_last, (i == n - 1));
            end
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || tf_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_done: got done=%b valid=%b, want 1 0", name, done, tf_valid);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: got done=%b busy=%b, want 0 0", name, done, busy);
        end
    endtask

    task automatic test_mode0;
        logic [P-1:0] e0 [4] = '{64'd3, 64'd9, 64'd10, 64'd13};
        logic [P-1:0] e1 [4] = '{64'd1, 64'd3, 64'd9, 64'd10};
        logic [P-1:0] e2 [4] = '{64'd0, 64'd0, 64'd0, 64'd0};
        logic [P-1:0] e3 [4] = '{64'd16, 64'd14, 64'd8, 64'd7};
        tf_ready = 1'b1;
        kick(1'b0, 4, 64'd17, 64'd3, 64'd3, 64'd1, 64'd34, 64'd16);
        run_check("mode0", e0, e1, e2, e3, 4);
    endtask

    task automatic test_mode1;
        logic [P-1:0] e0 [4] = '{64'd3, 64'd9, 64'd13, 64'd16};
        logic [P-1:0] e1 [4] = '{64'd3, 64'd9, 64'd13, 64'd16};
        logic [P-1:0] e2 [4] = '{64'd5, 64'd8, 64'd13, 64'd16};
        logic [P-1:0] e3 [4] = '{64'd0, 64'd0, 64'd0, 64'd0};
        tf_ready = 1'b1;
        kick(1'b1, 4, 64'd17, 64'd7, 64'd3, 64'd20, 64'd5, 64'd0);
        run_check("mode1", e0, e1, e2, e3, 4);
    endtask

    task automatic test_wide;
        logic [P-1:0] a0 [4] = '{64'h8000_0000_0000_0000, 64'd59, 64'd118, 64'd0};
        logic [P-1:0] a1 [4] = '{64'd5, 64'd10, 64'd20, 64'd0};
        logic [P-1:0] a2 [4] = '{64'd0, 64'd0, 64'd0, 64'd0};
        logic [P-1:0] a3 [4] = '{NBIG - 64'd1, NBIG - 64'd2, NBIG - 64'd4, 64'd0};
        logic [P-1:0] q0 [4] = '{64'h1_0000_0000, 64'd59, 64'd3481, 64'd0};
        logic [P-1:0] q1 [4] = '{NBIG - 64'd1, 64'd1, 64'd1, 64'd0};
        logic [P-1:0] q2 [4] = '{64'd2, 64'd4, 64'd16, 64'd0};
        logic [P-1:0] q3 [4] = '{64'd0, 64'd0, 64'd0, 64'd0};
        tf_ready = 1'b1;
        kick(1'b0, 3, NBIG, 64'd2, 64'h8000_0000_0000_0000, NBIG + 64'd5, 64'd0, NBIG - 64'd1);
        run_check("wide0", a0, a1, a2, a3, 3);
        kick(1'b1, 3, NBIG, 64'd2, 64'h1_0000_0000, NBIG - 64'd1, 64'd2, 64'd0);
        run_check("wide1", q0, q1, q2, q3, 3);
    endtask

    task automatic test_backpressure;
        logic [P-1:0] seq [7] = '{64'd3, 64'd3, 64'd3, 64'd3, 64'd9, 64'd10, 64'd13};
        int xf = 0;
        tf_ready = 1'b0;
        kick(1'b0, 4, 64'd17, 64'd3, 64'd3, 64'd0, 64'd0, 64'd0);
        for (int c = 0; c < 7; c++) begin
            tick();
            tf_ready = (c >= 3);
            n_cmp++;
            if (tf_valid !== 1'b1 || tf_out[P-1:0] !== seq[c] || tf_last !== (c == 6)) begin
                n_err++;
                $display("FAIL bp_cycle%0d: got valid=%b ch0=%0d last=%b, want 1 %0d %b",
                         c, tf_valid, tf_out[P-1:0], tf_last, seq[c], (c == 6));
            end
            if (tf_valid && tf_ready) xf++;
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || xf != 4) begin
            n_err++;
            $display("FAIL bp_done: got done=%b transfers=%0d, want 1 4", done, xf);
        end
        tick();
    endtask

    task automatic test_len0;
        int vseen = 0;
        tf_ready = 1'b1;
        kick(1'b0, 0, 64'd17, 64'd3, 64'd3, 64'd0, 64'd0, 64'd0);
        if (tf_valid) vseen++;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL len0_load: got busy=%b done=%b, want 1 0", busy, done);
        end
        tick();
        if (tf_valid) vseen++;
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL len0_done: got done=%b, want 1", done);
        end
        tick();
        if (tf_valid) vseen++;
        n_cmp++;
        if (busy !== 1'b0 || vseen != 0) begin
            n_err++;
            $display("FAIL len0_novalid: got busy=%b valid_cycles=%0d, want 0 0", busy, vseen);
        end
    endtask

    task automatic test_reset_mid;
        int dseen = 0;
        tf_ready = 1'b1;
        kick(1'b0, 4, 64'd17, 64'd3, 64'd3, 64'd0, 64'd0, 64'd0);
        tick(); tick(); tick();
        n_cmp++;
        if (tf_out[P-1:0] !== 64'd10) begin
            n_err++;
            $display("FAIL rstmid_term2: got %0d, want 10", tf_out[P-1:0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tf_out !== '0 || tf_valid !== 1'b0 || tf_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_async: got valid=%b last=%b busy=%b done=%b out=%h, want all zero",
                     tf_valid, tf_last, busy, done, tf_out);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done || busy) dseen++;
        end
        n_cmp++;
        if (dseen != 0) begin
            n_err++;
            $display("FAIL rstmid_nodone: got %0d busy/done cycles, want 0", dseen);
        end
        kick(1'b0, 2, 64'd17, 64'd3, 64'd3, 64'd0, 64'd0, 64'd0);
        tick();
        n_cmp++;
        if (tf_valid !== 1'b1 || tf_out[P-1:0] !== 64'd3) begin
            n_err++;
            $display("FAIL rstmid_restart0: got valid=%b ch0=%0d, want 1 3", tf_valid, tf_out[P-1:0]);
        end
        tick();
        n_cmp++;
        if (tf_out[P-1:0] !== 64'd9 || tf_last !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_restart1: got ch0=%0d last=%b, want 9 1", tf_out[P-1:0], tf_last);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_done: got done=%b, want 1", done);
        end
        tick();
    endtask

    task automatic test_start_ignored;
        logic [P-1:0] seq [4] = '{64'd3, 64'd9, 64'd10, 64'd13};
        tf_ready = 1'b1;
        kick(1'b0, 4, 64'd17, 64'd3, 64'd3, 64'd0, 64'd0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin
                start = 1'b1; mode = 1'b1; len = 13'd1; N_in = 64'd23; step_in = 64'd5; base_in = '1;
            end else begin
                start = 1'b0;
            end
            n_cmp++;
            if (tf_valid !== 1'b1 || tf_out[P-1:0] !== seq[i] || tf_last !== (i == 3)) begin
                n_err++;
                $display("FAIL ign_term%0d: got valid=%b ch0=%0d last=%b, want 1 %0d %b",
                         i, tf_valid, tf_out[P-1:0], tf_last, seq[i], (i == 3));
            end
        end
        tick();
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL ign_done: got done=%b, want 1", done);
        end
        tick(); tick();
        n_cmp++;
        if (busy !== 1'b0 || tf_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ign_idle: got busy=%b valid=%b, want 0 0", busy, tf_valid);
        end
    endtask

    task automatic test_max_len;
        int xf = 0, bad = 0, early_last = 0;
        bit seen = 0;
        tf_ready = 1'b1;
        kick(1'b0, 8191, 64'd17, 64'd1, 64'd1, 64'd1, 64'd1, 64'd1);
        for (int c = 0; c < 9000 && !seen; c++) begin
            tick();
            if (done) seen = 1;
            if (tf_valid && tf_ready) begin
                xf++;
                if (tf_out[P-1:0] !== 64'd1) bad++;
                if (tf_last && xf != 8191) early_last++;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL maxlen_timeout: got no done within 9000 cycles, want done");
        end
        n_cmp++;
        if (xf != 8191 || bad != 0 || early_last != 0) begin
            n_err++;
            $display("FAIL maxlen_count: got transfers=%0d badvals=%0d early_last=%0d, want 8191 0 0",
                     xf, bad, early_last);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_wide();
        test_backpressure();
        test_len0();
        test_reset_mid();
        test_start_ignored();
        test_max_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tf_stream_gen.md
TF_STREAM_GEN -- requirements
Module: tf_stream_gen

Interface
REQ-001 Parameter P_WIDTH, default 64: data/modulus width in bits.
REQ-002 Parameter NCH, default 4: number of parallel twiddle channels.
REQ-003 Parameter CNT_W, default 13: width of the term counter and the length input.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a sequence; sampled only in IDLE.
REQ-007 mode  input  1  0 = geometric progression (t*step); 1 = repeated squaring (t*t); latched at start.
REQ-008 len  input  CNT_W  number of terms per channel; latched at start.
REQ-009 N_in  input  P_WIDTH  modulus, N_in >= 2; latched at start.
REQ-010 step_in  input  P_WIDTH  common ratio for mode 0; latched at start.
REQ-011 base_in  input  NCH*P_WIDTH  channel c base in bits [c*P_WIDTH +: P_WIDTH]; latched at start.
REQ-012 tf_out  output  NCH*P_WIDTH  current term for every channel, using the same packing as base_in.
REQ-013 tf_valid  output  1  tf_out holds a valid term.
REQ-014 tf_ready  input  1  consumer accepts; a transfer occurs when tf_valid and tf_ready are both 1.
REQ-015 tf_last  output  1  high with tf_valid on the final term (index len-1).
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at sequence end.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-019 IDLE SHALL go to LOAD on start=1; in IDLE, tf_valid SHALL be 0.
REQ-020 LOAD SHALL take one cycle: it stores base_c mod N and step mod N, clears term counter k to 0, and goes to RUN, or goes directly to DONE when len=0.
REQ-021 In RUN, tf_valid SHALL be 1 and tf_out SHALL hold t_c(k).
- t_c(0) = base_c mod N.
- Mode 0: t_c(k+1) = (t_c(k) * step) mod N.
- Mode 1: t_c(k+1) = (t_c(k) * t_c(k)) mod N.
REQ-022 Each product SHALL be a full 2*P_WIDTH-bit product reduced modulo the latched N; result is always < N.
REQ-023 On each transfer in RUN, k SHALL increment and the next term SHALL appear on tf_out the following cycle (one term per cycle at full throughput).
REQ-024 On a transfer with k = len-1, the FSM SHALL go to DONE, and no further term is produced.
REQ-025 While tf_valid=1 and tf_ready=0, tf_out, tf_last, k and the FSM state SHALL hold unchanged.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 Latency: start sampled at cycle 0 -> LOAD at cycle 1 -> tf_valid=1 with t(0) at cycle 2.
REQ-028 start asserted while busy=1 SHALL be ignored; changes to inputs latched at start SHALL have no effect until the next start.
REQ-029 len = 2^CNT_W - 1 SHALL run to completion with no counter wrap-around.
REQ-030 All NCH channels SHALL advance in lockstep on a single handshake.

Reset
REQ-031 While rst_n=0, the block SHALL be in IDLE with tf_out=0, tf_valid=0, tf_last=0, busy=0, done=0, k=0, and all latched values at 0.
REQ-032 Reset asserted mid-sequence SHALL abort the sequence immediately, with no done pulse.
REQ-033 After reset release, the block SHALL require a new start.

Verification
REQ-034 Mode 0, N=17, base ch0=3, step=3, len=4, tf_ready=1 -> ch0 outputs 3, 9, 10, 13 on cycles 2-5; tf_last on cycle 5; done on cycle 6.
REQ-035 Mode 1, N=17, base ch0=3, len=4 -> ch0 outputs 3, 9, 13, 16; ch1 base 20 -> 3, 9, 13, 16 (base reduced mod N).
REQ-036 REQ-034 setup with tf_ready low for 3 cycles after the first term -> term 3 held for 3 cycles; sequence completes with 4 transfers total.
REQ-037 len=0 -> LOAD, then done pulse; tf_valid never asserted.
REQ-038 rst_n low during term 2 -> all outputs 0 asynchronously; no done; a new start with len=2 outputs 3, 9.
REQ-039 start pulsed during RUN with different base/len -> ignored; original sequence is unchanged.
